seq_detect_fsm: RTL
===================

# seq_detect_fsm

Parametrised serial pattern detector and the generalised successor of the team's fixed-graph X/Y Moore FSM. It samples a 1-bit serial input under an enable, compares the last PAT_W accepted bits against a runtime-loadable pattern, and raises a registered Moore output for each match. It supports overlapping or non-overlapping match modes and keeps a saturating match counter. It sits in the lcisc library as a reusable control/protocol-recognition primitive.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width; legal range ≥1.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = each match consumes its PAT_W bits.
- RESET_PAT, 4'b1011 (PAT_W bits), pattern register value after reset.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample-accept strobe; x is consumed only when en=1.
- x  in  1  serial data bit.
- pat_load  in  1  load pat_in into the pattern register and restart the hunt.
- pat_in  in  PAT_W  new pattern; bit PAT_W-1 is the oldest (first-received) bit.
- clear_cnt  in  1  synchronous clear of match_cnt.
- y  out  1  Moore output; high while the FSM is in HIT.
- match_cnt  out  CNT_W  saturating count of matches.
- filled  out  1  high when fill = PAT_W (history window valid).

## Operation
- Storage: pat[PAT_W-1:0], hist[PAT_W-1:0] (shift register, newest bit in bit 0), fill counter 0..PAT_W, state {HUNT, HIT}, match_cnt.
- Reset values: state=HUNT, y=0, hist=0, fill=0, filled=0, pat=RESET_PAT, match_cnt=0.
- Accept (en=1, pat_load=0): hist <= {hist[PAT_W-2:0], x}; fill <= min(fill+1, PAT_W).
- match = en & ~pat_load & (fill ≥ PAT_W-1) & ({hist[PAT_W-2:0], x} == pat). Reset zeros in hist never match, because fill gates the compare.
- On match with OVERLAP=0: fill <= 0. The next match needs PAT_W fresh bits. hist still shifts.
- FSM (next state):
  - HUNT → HIT on match; otherwise stays HUNT.
  - HIT → HIT on match; otherwise → HUNT. This includes en=0.
  - pat_load in any state → HUNT.
- y = (state == HIT): a one-cycle pulse per match, held high across back-to-back matches.
- pat_load: pat <= pat_in, hist <= 0, fill <= 0, state <= HUNT. It has priority over en in the same cycle, and that cycle's x is discarded. match_cnt is unaffected.
- match_cnt:
  - Increments by 1 on match and saturates at 2^CNT_W-1.
  - clear_cnt without match gives 0.
  - clear_cnt with match in the same cycle gives 1.
- en=0 cycles hold hist and fill, so gaps between accepted bits do not break a match.

## Timing
- Latency: y rises on the clock edge that accepts the completing bit, i.e. one cycle after that bit is presented. match_cnt updates on the same edge.
- y is purely registered-state-derived, with no combinational path from x, en or pat_load.
- Asynchronous reset clears all state immediately, including mid-HIT. y falls without a clock edge. First sample is accepted on the first rising edge after reset deasserts.
- filled rises on the edge where fill reaches PAT_W.
- An OVERLAP=0 match clears fill, so filled drops on the same edge that y rises.

## Test plan
- Basic match (PAT_W=4, pat=1011): after reset, stream x=1,0,1,1 with en=1 → y=0 for the first 3 edges, y=1 for exactly one cycle after the 4th edge, match_cnt=1.
- Overlap modes (pat=1111, 7 consecutive 1s):
  - OVERLAP=1 → y high for 4 consecutive cycles, match_cnt=4.
  - OVERLAP=0 → a single 1-cycle y pulse after bit 4, match_cnt=1.
  - OVERLAP=0 with an 8th 1 → second pulse after bit 8, match_cnt=2.
- Gating and fill:
  - pat=0000: 3 accepted 0s after reset → no match; 4th accepted 0 → y pulse.
  - Stream 1,0,1,1 with en=0 gaps of 2 cycles between bits → exactly one y pulse, after the last accepted bit.
- pat_load mid-stream: accept 1,0,1, then pat_load=1 with pat_in=1011 and en=1, x=1 → no match. Next 1,0,1,1 → one pulse; match_cnt increments by 1 only.
- Counter rules (CNT_W=2): 5 matches → match_cnt=3 (saturated). clear_cnt coincident with a match → match_cnt=1. clear_cnt alone → 0.
- Async reset while y=1: assert reset between clock edges → y, match_cnt and filled go to 0 immediately. Pattern returns to RESET_PAT; verify with a stream of 1,0,1,1 → pulse.

Source files
------------

// File: rtl/seq_detect_fsm_if.sv
// Bundle of the serial-detector control, data and status signals.
// The master drives the stream and pattern controls; the slave is the detector.
interface seq_detect_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             clear_cnt;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             filled;

  modport master (
    output en, x, pat_load, pat_in, clear_cnt,
    input  y, match_cnt, filled
  );

  modport slave (
    input  en, x, pat_load, pat_in, clear_cnt,
    output y, match_cnt, filled
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: compares the last PAT_W accepted bits against a loadable
// pattern, raises a Moore HIT output per match and keeps a saturating match count.
module seq_detect_fsm #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter bit               OVERLAP   = 1'b1,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011)
) (
  input  logic          clk,
  input  logic          reset,
  seq_detect_fsm_if.slave bus
);

  localparam int               FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0]    FILL_MIN  = FW'(PAT_W - 1);
  localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    HIT  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] window_s;
  logic             match_s;

  // The fill gate keeps reset/reload zeros in hist from ever forming a match.
  assign window_s = {hist_q[PAT_W-2:0], bus.x};
  assign match_s  = bus.en & ~bus.pat_load & (fill_q >= FILL_MIN) & (window_s == pat_q);

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      pat_q   <= RESET_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: pattern reload, history shift, fill tracking, FSM and counter.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = HUNT;
    end else begin
      if (bus.en) begin
        hist_d = window_s;
        if (match_s && !OVERLAP) begin
          fill_d = '0;
        end else if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FILL_ONE;
        end else begin
          fill_d = fill_q;
        end
      end else begin
        hist_d = hist_q;
        fill_d = fill_q;
      end

      case (state_q)
        HUNT:    state_d = match_s ? HIT : HUNT;
        HIT:     state_d = match_s ? HIT : HUNT;
        default: state_d = HUNT;
      endcase
    end

    // A clear coincident with a match leaves the count at one.
    if (bus.clear_cnt) begin
      cnt_d = match_s ? CNT_ONE : '0;
    end else if (match_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign bus.y         = (state_q == HIT);
  assign bus.match_cnt = cnt_q;
  assign bus.filled    = (fill_q == FILL_FULL);

endmodule
